// File: rtl/fs_pkg.sv
// Shared constants for the registered ripple-borrow subtractor.
package fs_pkg;

  // Widest operand the borrow chain is qualified for.
  localparam int unsigned FS_MAX_WIDTH = 64;

  // Difference register value while in reset; sliced down to the instance width.
  localparam logic [FS_MAX_WIDTH-1:0] FS_DIFF_RST = '0;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full-subtractor cell: diff = a - b - bin, with borrow-out.
module full_subtractor_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);

  logic ab_eq;

  // Borrow is generated when a=0,b=1 and propagated when a==b.
  always_comb begin
    ab_eq  = ~(a_i ^ b_i);
    diff_o = a_i ^ b_i ^ bin_i;
    bout_o = (~a_i & b_i) | (ab_eq & bin_i);
  end

endmodule

// File: rtl/full_subtractor.sv
// Registered WIDTH-bit ripple-borrow subtractor: {bout, diff} <= a - b - bin.
module full_subtractor
  import fs_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > FS_MAX_WIDTH) begin : g_bad_width
    $error("full_subtractor: WIDTH out of range");
  end

  logic [WIDTH:0]   br;
  logic [WIDTH-1:0] chain_diff;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             valid_q, valid_d;

  assign br[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_bit u_bit (
      .a_i   (a[i]),
      .b_i   (b[i]),
      .bin_i (br[i]),
      .diff_o(chain_diff[i]),
      .bout_o(br[i+1])
    );
  end

  // Load the chain result only on accepted operands, so idle inputs (even X) never reach outputs.
  always_comb begin
    diff_d  = diff_q;
    bout_d  = bout_q;
    valid_d = in_valid;
    if (in_valid) begin
      diff_d = chain_diff;
      bout_d = br[WIDTH];
    end
  end

  // Output register stage; reset clears any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q  <= FS_DIFF_RST[WIDTH-1:0];
      bout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      valid_q <= valid_d;
    end
  end

  assign diff      = diff_q;
  assign bout      = bout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_full_subtractor.sv
// Directed-vector bench for full_subtractor at WIDTH=1 and WIDTH=8.
module tb_full_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       a1, b1, bin1;
  logic       diff1, bout1, ov1;
  logic [7:0] a8, b8;
  logic       bin8;
  logic [7:0] diff8;
  logic       bout8, ov8;

  int n_checks = 0;
  int n_bad    = 0;

  full_subtractor #(.WIDTH(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a1),
    .b        (b1),
    .bin      (bin1),
    .diff     (diff1),
    .bout     (bout1),
    .out_valid(ov1)
  );

  full_subtractor #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a8),
    .b        (b8),
    .bin      (bin8),
    .diff     (diff8),
    .bout     (bout8),
    .out_valid(ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_db [8];
  logic [8:0] exp9;

  initial begin
    exp_db = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    {a1, b1, bin1} = 3'b000;
    a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
    step();
    check("rst_diff1", {63'd0, diff1}, 64'd0);
    check("rst_bout1", {63'd0, bout1}, 64'd0);
    check("rst_ov1", {63'd0, ov1}, 64'd0);
    check("rst_diff8", {56'd0, diff8}, 64'd0);
    #4 rst_n = 1'b1;
    step();

    // Exhaustive 1-bit table, back to back.
    in_valid = 1'b1;
    {a1, b1, bin1} = 3'd0;
    for (int v = 0; v < 8; v++) begin
      step();
      check($sformatf("tt%0d_diff", v), {63'd0, diff1}, {63'd0, exp_db[v][1]});
      check($sformatf("tt%0d_bout", v), {63'd0, bout1}, {63'd0, exp_db[v][0]});
      check($sformatf("tt%0d_ov", v), {63'd0, ov1}, 64'd1);
      if (v < 7) {a1, b1, bin1} = 3'(v + 1);
    end

    // Async reset between edges.
    {a1, b1, bin1} = 3'b100;
    step();
    check("ar_pre_diff", {63'd0, diff1}, 64'd1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_diff", {63'd0, diff1}, 64'd0);
    check("ar_bout", {63'd0, bout1}, 64'd0);
    check("ar_ov", {63'd0, ov1}, 64'd0);
    #1 rst_n = 1'b1;
    step();
    check("ar_post_ov", {63'd0, ov1}, 64'd0);

    // in_valid gap: hold result while inputs change, including X on the wide unit.
    in_valid = 1'b1;
    {a1, b1, bin1} = 3'b100;
    a8 = 8'h00; b8 = 8'h01; bin8 = 1'b1;
    step();
    check("gap_diff", {63'd0, diff1}, 64'd1);
    check("gap_bout", {63'd0, bout1}, 64'd0);
    check("w8_wrap_diff", {56'd0, diff8}, 64'hFE);
    check("w8_wrap_bout", {63'd0, bout8}, 64'd1);
    in_valid = 1'b0;
    {a1, b1, bin1} = 3'b111;
    a8 = 'x; b8 = 'x; bin8 = 1'bx;
    step();
    check("gap_hold_diff", {63'd0, diff1}, 64'd1);
    check("gap_hold_bout", {63'd0, bout1}, 64'd0);
    check("gap_ov", {63'd0, ov1}, 64'd0);
    check("x_hold_diff8", {56'd0, diff8}, 64'hFE);
    check("x_hold_bout8", {63'd0, bout8}, 64'd1);
    step();
    check("gap_hold2_diff", {63'd0, diff1}, 64'd1);

    in_valid = 1'b1;
    a8 = 8'hA5; b8 = 8'h25; bin8 = 1'b0;
    step();
    check("w8_a5_diff", {56'd0, diff8}, 64'h80);
    check("w8_a5_bout", {63'd0, bout8}, 64'd0);
    check("w8_a5_ov", {63'd0, ov8}, 64'd1);

    // Back-to-back random vectors against the arithmetic reference.
    for (int i = 0; i < 200; i++) begin
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      bin8 = 1'($urandom);
      exp9 = {1'b0, a8} - {1'b0, b8} - {8'd0, bin8};
      step();
      check($sformatf("rnd%0d", i), {55'd0, bout8, diff8}, {55'd0, exp9});
      check($sformatf("rnd%0d_ov", i), {63'd0, ov8}, 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("end_ov8", {63'd0, ov8}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
